srp_out_buff_reader: RTL and testbench
======================================

SRP_OUT_BUFF_READER -- requirements
Module: srp_out_buff_reader

Interface
REQ-001 The block SHALL have parameter DEPTH, default 768, the number of buffer entries.
REQ-002 The block SHALL have parameter AW, default 10, the buffer address width.
REQ-003 The block SHALL have parameter DW, default 8, the buffer data width.
REQ-004 clk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  one-cycle pulse that begins a read pass.
REQ-007 len  in  AW  number of bytes in the pass, sampled with start.
REQ-008 bram_en  out  1  read enable to the output buffer RAM; bram_we SHALL be tied 0.
REQ-009 bram_addr  out  AW  RAM read address.
REQ-010 bram_dout  in  DW  RAM registered read data, valid one cycle after bram_en.
REQ-011 m_data  out  DW  stream data.
REQ-012 m_valid  out  1  stream valid.
REQ-013 m_last  out  1  high on the final beat of a pass.
REQ-014 m_ready  in  1  stream ready from the consumer.
REQ-015 busy  out  1  high from the accepted start until the last beat is accepted.
REQ-016 done  out  1  one-cycle pulse after the last beat is accepted.

Function
REQ-017 The FSM SHALL have three states: IDLE -> READ on accepted start; READ -> DRAIN after the final address is issued; DRAIN -> IDLE when the FIFO is empty and the last beat is accepted.
- len > DEPTH SHALL be clamped to DEPTH.
- start with len == 0 SHALL pulse done on the next cycle, emit no beats and stay in IDLE.
REQ-018 start SHALL be ignored when busy is high.
REQ-019 Addresses SHALL be issued in order: 0, 1, ..., len-1.
REQ-020 A read SHALL be issued (bram_en=1) only when outstanding reads plus FIFO occupancy < 2, so no data is lost under backpressure.
REQ-021 Read data SHALL be captured into a 2-entry FIFO one cycle after bram_en.
- m_valid SHALL be high whenever the FIFO is non-empty.
- A beat transfers when m_valid && m_ready.
REQ-022 Latency: with m_ready held high, bram_en SHALL assert the cycle after start is sampled, and the first m_valid SHALL follow 2 cycles later.
REQ-023 With m_ready held high, throughput SHALL be one beat per cycle; output data SHALL equal RAM[0..len-1] in order with no gaps.
REQ-024 m_data and m_last SHALL hold stable while m_valid && !m_ready.
REQ-025 m_last SHALL be high only on the beat read from address len-1.
REQ-026 Address counter width SHALL be AW.
- The counter SHALL never exceed len-1.
- It SHALL reset to 0 at each accepted start.

Reset
REQ-027 While rst_n=0:
- state SHALL be IDLE;
- bram_en, bram_addr, m_valid, m_last, busy and done SHALL be 0;
- FIFO and counters SHALL be cleared.
REQ-028 Reset mid-pass SHALL abort the pass with no done pulse; the first start after release SHALL begin a fresh pass at address 0.

Configuration
REQ-029 Macro SRP_RD_LOOP_EN:
- Defined: an input port rpt (1 bit) SHALL exist. If rpt is high when the final address issues, addressing SHALL wrap to 0 and the pass SHALL repeat without a bubble. m_last SHALL still mark each pass's final beat, and done SHALL pulse only after a pass that ends with rpt low.
- Undefined: the rpt port SHALL be absent and every pass SHALL be single-shot.

Structure
REQ-030 Package srp_rd_pkg SHALL hold the FSM state typedef (IDLE, READ, DRAIN) and the default DEPTH/AW/DW constants.
REQ-031 The 2-entry FIFO SHALL be a sub-module named srp_skid_fifo2, parameterised by DW plus a 1-bit last flag.

Verification
REQ-032 RAM preloaded with RAM[i]=i[7:0]; start, len=768, m_ready=1 -> 768 consecutive beats of 0x00..0xFF repeating, m_last on beat 768, done one cycle later.
REQ-033 len=4, m_ready toggling 1,0,1,0 -> beats 0,1,2,3 with no loss or duplication, data stable while stalled, at most 2 reads outstanding.
REQ-034 len=0 -> done pulses next cycle, m_valid stays 0; len=1000 -> exactly 768 beats.
REQ-035 Second start during busy at len=10 -> ignored; exactly 10 beats from the first pass.
REQ-036 rst_n low for 1 cycle at beat 100 of a 768 pass -> all outputs 0, no done; a new start with len=3 yields beats 0,1,2.
REQ-037 With SRP_RD_LOOP_EN defined, len=3, rpt=1 for 2 passes then 0 -> stream 0,1,2,0,1,2,0,1,2 with m_last on every third beat, done once at the end.

Source files
------------

// File: rtl/srp_rd_pkg.sv
// srp_rd_pkg: shared constants, FSM state encoding and a small credit helper
// for the output-buffer reader (srp_out_buff_reader) and its skid FIFO.
package srp_rd_pkg;

    // Default geometry of the output buffer RAM.
    localparam int SRP_DEPTH = 768;
    localparam int SRP_AW    = 10;
    localparam int SRP_DW    = 8;

    // Number of entries in the read-data skid FIFO.
    localparam int SRP_FIFO_DEPTH = 2;

    // Reader FSM state encoding.
    typedef logic [1:0] state_t;
    localparam state_t IDLE  = 2'd0;
    localparam state_t READ  = 2'd1;
    localparam state_t DRAIN = 2'd2;

    // Slots that will still be committed after this cycle: the read in flight
    // plus buffered entries, minus the beat the consumer takes this cycle.
    function automatic logic [1:0] slots_in_use(input logic       pend,
                                                input logic [1:0] cnt,
                                                input logic       pop);
        return {1'b0, pend} + cnt - {1'b0, pop};
    endfunction

endpackage

// File: rtl/srp_out_buff_reader_fifo.sv
// srp_skid_fifo2: two-entry FIFO holding RAM read data plus an end-of-pass
// flag. The head entry stays put until popped, so the stream output is
// stable while the consumer stalls.
module srp_skid_fifo2
    import srp_rd_pkg::*;
#(
    parameter int DW = SRP_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic [1:0]    count
);

    localparam logic [1:0] FULL_CNT = 2'(SRP_FIFO_DEPTH);

    logic [DW:0] mem_q [SRP_FIFO_DEPTH];
    logic [DW:0] mem_d [SRP_FIFO_DEPTH];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        pop_ok;
    logic        push_ok;

    assign pop_ok  = pop && (count_q != 2'd0);
    assign push_ok = push && ((count_q != FULL_CNT) || pop_ok);

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        for (int i = 0; i < SRP_FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = {push_last, push_data};
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    // FIFO registers, cleared by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SRP_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            for (int i = 0; i < SRP_FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rd_ptr_q][DW-1:0];
    assign out_last  = mem_q[rd_ptr_q][DW] & out_valid;
    assign count     = count_q;

endmodule

// File: rtl/srp_out_buff_reader.sv
// srp_out_buff_reader: streams len bytes out of the output buffer RAM
// (addresses 0..len-1) onto a valid/ready stream with m_last on the final
// beat and a done pulse once that beat is taken.
// Optional feature macro SRP_RD_LOOP_EN adds the rpt input: when rpt is high
// as the final address issues, addressing wraps and the pass repeats.
module srp_out_buff_reader
    import srp_rd_pkg::*;
#(
    parameter int DEPTH = SRP_DEPTH,
    parameter int AW    = SRP_AW,
    parameter int DW    = SRP_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] len,
`ifdef SRP_RD_LOOP_EN
    input  logic          rpt,
`endif
    output logic          bram_en,
    output logic          bram_we,
    output logic [AW-1:0] bram_addr,
    input  logic [DW-1:0] bram_dout,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_last,
    input  logic          m_ready,
    output logic          busy,
    output logic          done
);

    localparam logic [AW:0]   DEPTH_W    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] DEPTH_LAST = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] last_addr_q, last_addr_d;
    logic          rd_pend_q, rd_pend_d;
    logic          rd_last_q, rd_last_d;
    logic          done_q, done_d;

    logic          start_ok;
    logic          len_over;
    logic [AW-1:0] len_last;
    logic          at_final;
    logic          rd_issue;
    logic          rpt_now;
    logic          drain_done;

    logic          fifo_valid;
    logic [DW-1:0] fifo_data;
    logic          fifo_last;
    logic [1:0]    fifo_count;
    logic          fifo_pop;

`ifdef SRP_RD_LOOP_EN
    assign rpt_now = rpt;
`else
    assign rpt_now = 1'b0;
`endif

    // A start only counts while idle; a busy pass ignores it.
    assign start_ok = start && (state_q == IDLE);

    // Final address of the pass, with oversize lengths clamped to the buffer.
    assign len_over = ({1'b0, len} > DEPTH_W);
    assign len_last = len_over ? DEPTH_LAST : (len - AW'(1));

    assign at_final = (addr_q == last_addr_q);
    assign fifo_pop = fifo_valid && m_ready;

    // Issue only when the data it returns is guaranteed a FIFO slot; counting
    // this cycle's pop lets a ready consumer sustain one beat per cycle.
    assign rd_issue = (state_q == READ) &&
                      (slots_in_use(rd_pend_q, fifo_count, fifo_pop) < 2'd2);

    // The pass is over once its final beat leaves and nothing else is queued.
    assign drain_done = (state_q == DRAIN) && fifo_pop && fifo_last &&
                        (fifo_count == 2'd1) && !rd_pend_q;

    // Reader FSM, address counter and read pipeline bookkeeping.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        done_d      = 1'b0;
        rd_pend_d   = rd_issue;
        rd_last_d   = rd_issue && at_final;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d     = READ;
                        addr_d      = '0;
                        last_addr_d = len_last;
                    end
                end
            end
            READ: begin
                if (rd_issue) begin
                    if (at_final) begin
                        if (rpt_now) begin
                            addr_d = '0;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                if (drain_done) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers; reset abandons any pass in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            rd_pend_q   <= 1'b0;
            rd_last_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            rd_pend_q   <= rd_pend_d;
            rd_last_q   <= rd_last_d;
            done_q      <= done_d;
        end
    end

    // Registered RAM data arrives one cycle after the read and lands here.
    srp_skid_fifo2 #(
        .DW(DW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rd_pend_q),
        .push_data (bram_dout),
        .push_last (rd_last_q),
        .pop       (fifo_pop),
        .out_valid (fifo_valid),
        .out_data  (fifo_data),
        .out_last  (fifo_last),
        .count     (fifo_count)
    );

    assign bram_en   = rd_issue;
    assign bram_we   = 1'b0;
    assign bram_addr = addr_q;
    assign m_valid   = fifo_valid;
    assign m_data    = fifo_data;
    assign m_last    = fifo_last;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_srp_out_buff_reader.sv
// Testbench for srp_out_buff_reader: directed passes with a scoreboard of
// expected beats; a negedge monitor compares every accepted beat.
// Define SRP_RD_LOOP_EN to also exercise the repeat feature.
module tb_srp_out_buff_reader;

    localparam int DEPTH = 768;
    localparam int AW    = 10;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] len;
    logic          bram_en;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready;
    logic          busy;
    logic          done;
`ifdef SRP_RD_LOOP_EN
    logic          rpt;
    bit            loop_mode = 1'b0;
    int            loop_finals = 0;
`endif

    logic [DW-1:0] ram [DEPTH];
    logic [DW:0]   exp_q [$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int beats_in_test = 0;
    int first_beat_cyc = 0;
    int last_beat_cyc = 0;
    int issued = 0;
    int popped = 0;
    int max_outst = 0;
    int ready_mode = 0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    srp_out_buff_reader #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .len      (len),
`ifdef SRP_RD_LOOP_EN
        .rpt      (rpt),
`endif
        .bram_en  (bram_en),
        .bram_we  (bram_we),
        .bram_addr(bram_addr),
        .bram_dout(bram_dout),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_last   (m_last),
        .m_ready  (m_ready),
        .busy     (busy),
        .done     (done)
    );

    // Free-running clock, 10 ns period.
    always #5 clk = ~clk;

    // Cycle counter used for latency and throughput measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Output buffer RAM model with registered read data.
    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i);
    end
    always @(posedge clk) begin
        if (bram_en) bram_dout <= ram[bram_addr];
    end

    // Consumer ready: held high, or toggling every cycle in mode 1.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) m_ready = ~m_ready;
        else m_ready = 1'b1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Monitor: scoreboard compare, stall stability, outstanding reads, done.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!m_valid || m_data !== prev_data || m_last !== prev_last) begin
                    errors++;
                    $display("[TB] FAIL stall_hold: got valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                             m_valid, m_data, m_last, prev_data, prev_last);
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            if (bram_en) issued++;
            if (m_valid && m_ready) begin
                popped++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL beat_unexpected: got data=%h last=%b expected no beat", m_data, m_last);
                end else begin
                    logic [DW:0] e;
                    e = exp_q.pop_front();
                    if ({m_last, m_data} !== e) begin
                        errors++;
                        $display("[TB] FAIL beat_data: got last=%b data=%h expected last=%b data=%h",
                                 m_last, m_data, e[DW], e[DW-1:0]);
                    end
                end
                if (beats_in_test == 0) first_beat_cyc = cyc;
                beats_in_test++;
                if (m_last) last_beat_cyc = cyc;
            end
            if (issued - popped > max_outst) max_outst = issued - popped;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
`ifdef SRP_RD_LOOP_EN
            if (loop_mode && bram_en && bram_addr == AW'(2)) begin
                rpt = (loop_finals < 2);
                loop_finals++;
            end
`endif
        end
    end

    task automatic applyStimulus(input int n_len, input bit expect_beats);
        int n;
        n = (n_len > DEPTH) ? DEPTH : n_len;
        @(posedge clk); #1;
        start = 1'b1;
        len   = AW'(n_len);
        if (expect_beats) begin
            for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), DW'(i)});
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input string name);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput({name, "_done_seen"}, 32'(done_cnt != d0), 1);
    endtask

    task automatic clearStats();
        beats_in_test = 0;
        issued        = 0;
        popped        = 0;
        max_outst     = 0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d0;
        int n;
        rst_n   = 1'b0;
        start   = 1'b0;
        len     = '0;
        m_ready = 1'b1;
`ifdef SRP_RD_LOOP_EN
        rpt = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", 32'({bram_en, bram_addr, m_valid, m_last, busy, done}), 0);
        checkOutput("bram_we_tied", 32'(bram_we), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full-buffer pass with m_ready high: latency, order, throughput, done.
        $display("[TB] test: full pass len=768");
        clearStats();
        applyStimulus(768, 1'b1);
        @(negedge clk);
        checkOutput("lat_bram_en", 32'(bram_en), 1);
        checkOutput("lat_addr0", 32'(bram_addr), 0);
        checkOutput("busy_set", 32'(busy), 1);
        checkOutput("lat_valid_c1", 32'(m_valid), 0);
        @(negedge clk);
        checkOutput("lat_valid_c2", 32'(m_valid), 0);
        @(negedge clk);
        checkOutput("lat_valid_c3", 32'(m_valid), 1);
        waitDone(2000, "full");
        checkOutput("full_beats", beats_in_test, 768);
        checkOutput("full_no_gaps", last_beat_cyc - first_beat_cyc, 767);
        checkOutput("full_done_after_last", done_cyc - last_beat_cyc, 1);
        checkOutput("full_busy_clear", 32'(busy), 0);
        checkOutput("full_queue_empty", exp_q.size(), 0);
        repeat (3) @(negedge clk);

        // Short pass under a toggling consumer.
        $display("[TB] test: len=4 with toggling ready");
        clearStats();
        ready_mode = 1;
        applyStimulus(4, 1'b1);
        waitDone(100, "toggle");
        checkOutput("toggle_beats", beats_in_test, 4);
        checkOutput("toggle_outstanding_le2", 32'(max_outst <= 2), 1);
        checkOutput("toggle_queue_empty", exp_q.size(), 0);
        ready_mode = 0;
        repeat (3) @(negedge clk);

        // Zero-length pass.
        $display("[TB] test: len=0");
        clearStats();
        d0 = done_cnt;
        applyStimulus(0, 1'b1);
        @(negedge clk);
        checkOutput("len0_done_pulse", 32'(done), 1);
        checkOutput("len0_busy", 32'(busy), 0);
        checkOutput("len0_no_read", 32'(bram_en), 0);
        @(negedge clk);
        checkOutput("len0_done_low", 32'(done), 0);
        repeat (4) @(negedge clk);
        checkOutput("len0_no_beats", beats_in_test, 0);
        checkOutput("len0_done_once", done_cnt - d0, 1);

        // Oversize length clamps to the buffer depth.
        $display("[TB] test: len=1000 clamps");
        clearStats();
        applyStimulus(1000, 1'b1);
        waitDone(2000, "clamp");
        repeat (5) @(negedge clk);
        checkOutput("clamp_beats", beats_in_test, 768);
        checkOutput("clamp_queue_empty", exp_q.size(), 0);

        // A start during busy is ignored.
        $display("[TB] test: start while busy");
        clearStats();
        d0 = done_cnt;
        applyStimulus(10, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("busy_mid_pass", 32'(busy), 1);
        @(posedge clk); #1;
        start = 1'b1;
        len   = AW'(5);
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(200, "busyign");
        repeat (20) @(negedge clk);
        checkOutput("busyign_beats", beats_in_test, 10);
        checkOutput("busyign_done_once", done_cnt - d0, 1);
        checkOutput("busyign_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a full pass, then a fresh short pass.
        $display("[TB] test: reset mid-pass");
        clearStats();
        applyStimulus(768, 1'b1);
        n = 0;
        while (beats_in_test < 100 && n < 1000) begin
            @(negedge clk); #1;
            n++;
        end
        checkOutput("rst_reached_beat100", 32'(beats_in_test >= 100), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_outputs", 32'({bram_en, bram_addr, m_valid, m_last, busy, done}), 0);
        exp_q.delete();
        d0 = done_cnt;
        @(negedge clk); #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rst_no_done", done_cnt - d0, 0);
        checkOutput("rst_idle_after", 32'({m_valid, busy}), 0);
        clearStats();
        applyStimulus(3, 1'b1);
        @(negedge clk);
        checkOutput("rst_fresh_addr0", 32'({bram_en, bram_addr}), 32'({1'b1, AW'(0)}));
        waitDone(100, "rst_fresh");
        checkOutput("rst_fresh_beats", beats_in_test, 3);
        checkOutput("rst_fresh_queue_empty", exp_q.size(), 0);

`ifdef SRP_RD_LOOP_EN
        // Repeat feature: two wraps then a final pass, one done at the end.
        $display("[TB] test: loop len=3 three passes");
        repeat (3) @(negedge clk);
        clearStats();
        d0 = done_cnt;
        rpt         = 1'b1;
        loop_finals = 0;
        loop_mode   = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 3; i++) exp_q.push_back({(i == 2), DW'(i)});
        end
        applyStimulus(3, 1'b1);
        waitDone(100, "loop");
        repeat (10) @(negedge clk);
        checkOutput("loop_beats", beats_in_test, 9);
        checkOutput("loop_done_once", done_cnt - d0, 1);
        checkOutput("loop_no_gaps", last_beat_cyc - first_beat_cyc, 8);
        checkOutput("loop_queue_empty", exp_q.size(), 0);
        loop_mode = 1'b0;
        rpt       = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
